uart_receiver: RTL

Front-end deserialiser for the serial link. It oversamples the asynchronous line `din`, detects and validates start bits, and recovers 8N1 frames LSB-first. Each recovered byte is presented on a valid/ready output for the downstream serial_transceiver stage. Framing errors and overruns are flagged as single-cycle pulses.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_sampler.sv | 69 ++++++
 rtl/uart_receiver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam int DEF_CLKS_PER_BIT = 5208;
    localparam int DEF_DATA_BITS    = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, per-bit sample counter and 3-sample majority vote.
// bit_tick strobes at the decision point, bit_end on the last cycle of a bit.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    input  logic clear,
    output logic ds,
    output logic bit_val,
    output logic bit_tick,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int M  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          smp0;
    logic          smp1;

    // Synchroniser resets to the idle-line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en || clear) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp0 <= 1'b1;
            smp1 <= 1'b1;
        end else begin
            if (en && cnt == CNT_S0) smp0 <= sync2;
            if (en && cnt == CNT_S1) smp1 <= sync2;
        end
    end

    // Third sample is the live synchronised line at the decision cycle.
    assign ds       = sync2;
    assign bit_val  = majority3(smp0, smp1, sync2);
    assign bit_tick = en && (cnt == CNT_DEC);
    assign bit_end  = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit validation, LSB-first deserialisation and a
// single-entry valid/ready holding register with framing/overrun pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | line high, waiting for a falling edge on ds
//   START     | verifying the start bit; majority high means a glitch
//   DATA      | shifting in DATA_BITS bits, LSB first
//   STOP      | deciding the stop bit; good stop delivers, bad stop flags
//   WAIT_HIGH | after a framing error, wait for the line to return high
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    state_t               state;
    state_t               state_nx;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    logic ds;
    logic bit_val;
    logic bit_tick;
    logic bit_end;
    logic busy;
    logic busy_nx;
    logic deliver;
    logic stop_bad;

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .en      (busy),
        .clear   (!busy_nx),
        .ds      (ds),
        .bit_val (bit_val),
        .bit_tick(bit_tick),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!ds) state_nx = START;
            end
            START: begin
                if (bit_tick && bit_val) begin
                    state_nx = IDLE;
                end else if (bit_end) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_idx == LAST_BIT) state_nx = STOP;
            end
            STOP: begin
                // Leave at the decision point so the next start edge is caught early.
                if (bit_tick) state_nx = bit_val ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (ds) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == START) || (state == DATA) || (state == STOP);
        busy_nx  = (state_nx == START) || (state_nx == DATA) || (state_nx == STOP);
        deliver  = (state == STOP) && bit_tick && bit_val;
        stop_bad = (state == STOP) && bit_tick && !bit_val;
    end

    always_ff @(posedge clk) begin
        if (rst || state != DATA) begin
            bit_idx <= '0;
        end else if (bit_end) begin
            bit_idx <= bit_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (state == DATA && bit_tick) begin
            shift_reg[bit_idx[IW-2:0]] <= bit_val;
        end
    end

    // Holding register: a new byte may replace the old one only in the cycle it is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= deliver && out_valid && !out_ready;
            if (deliver && (!out_valid || out_ready)) begin
                out_data  <= shift_reg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
